// File: rtl/matraptor_pkg.sv
// Shared types for the MatRaptor fill-phase front end: queue entry layout and core FSM states.
package matraptor_pkg;

    localparam int PKG_DATA_W = 32;
    localparam int PKG_IDX_W  = 16;

    // Entry widths are fixed here; the core/PE DATA_W and IDX_W must match these.
    typedef struct packed {
        logic [PKG_DATA_W-1:0] val;
        logic [PKG_IDX_W-1:0]  col;
    } entry_t;

    typedef enum logic [1:0] {IDLE, FILL, CLOSE} core_state_t;

endpackage

// File: rtl/matraptor_spgemm_core_pe.sv
// One processing element: splits an output row into sorted column runs, one run per queue.
module matraptor_pe
    import matraptor_pkg::*;
#(
    parameter int DATA_W  = PKG_DATA_W,
    parameter int IDX_W   = PKG_IDX_W,
    parameter int NQ      = 8,
    parameter int Q_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              first,
    input  logic              clear,
    input  logic [DATA_W-1:0] val,
    input  logic [IDX_W-1:0]  col
);
    localparam int QS_W   = (NQ > 1) ? $clog2(NQ) : 1;
    localparam int PTR_W  = $clog2(Q_DEPTH) + 1;
    localparam int ADDR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;

    entry_t                   queue_mem [NQ][Q_DEPTH];
    logic [NQ-1:0][PTR_W-1:0] wr_ptr;
    logic [QS_W-1:0]          q_sel;
    logic [QS_W-1:0]          nxt_q;
    logic [IDX_W-1:0]         last_col;
    logic                     overflow;
    logic                     full;

    // A non-ascending column starts a new run in the next queue.
    always_comb begin
        nxt_q = q_sel;
        if (first)
            nxt_q = '0;
        else if (col <= last_col)
            nxt_q = (q_sel == QS_W'(NQ - 1)) ? '0 : q_sel + 1'b1;
    end

    assign full = (wr_ptr[nxt_q] == PTR_W'(Q_DEPTH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            q_sel    <= '0;
            last_col <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            q_sel    <= nxt_q;
            last_col <= col;
            if (full)
                overflow <= 1'b1;
            else
                wr_ptr[nxt_q] <= wr_ptr[nxt_q] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clear && !full)
            queue_mem[nxt_q][wr_ptr[nxt_q][ADDR_W-1:0]] <= '{val: val, col: col};
    end

endmodule

// File: rtl/matraptor_spgemm_core.sv
// Fill-phase front end: steers each output row's triples to its owner PE and signals row close.
module matraptor_spgemm_core
    import matraptor_pkg::*;
#(
    parameter int DATA_W  = PKG_DATA_W,
    parameter int IDX_W   = PKG_IDX_W,
    parameter int NQ      = 8,
    parameter int Q_DEPTH = 256,
    parameter int NUM_PES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_val,
    input  logic [IDX_W-1:0]   in_row,
    input  logic [IDX_W-1:0]   in_col,
    input  logic               in_last,
    output logic [NUM_PES-1:0] pe_row_done
);
    localparam int                 PE_W   = (NUM_PES > 1) ? $clog2(NUM_PES) : 1;
    localparam logic [NUM_PES-1:0] PE_ONE = 1;

    core_state_t      state;
    logic [IDX_W-1:0] cur_row;
    logic [PE_W-1:0]  in_pe;
    logic [PE_W-1:0]  cur_pe;
    logic             accept;

    function automatic logic [PE_W-1:0] owner(input logic [IDX_W-1:0] row);
        return (NUM_PES > 1) ? row[PE_W-1:0] : '0;
    endfunction

    assign in_pe  = owner(in_row);
    assign cur_pe = owner(cur_row);

    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE:    in_ready = 1'b1;
                FILL:    in_ready = (in_row == cur_row);
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid && in_ready;

    // A triple for a different row closes the current one and waits for IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cur_row     <= '0;
            pe_row_done <= '0;
        end else begin
            pe_row_done <= '0;
            case (state)
                IDLE: if (accept) begin
                    cur_row <= in_row;
                    if (in_last) begin
                        state       <= CLOSE;
                        pe_row_done <= PE_ONE << in_pe;
                    end else begin
                        state <= FILL;
                    end
                end
                FILL: if ((accept && in_last) || (in_valid && !in_ready)) begin
                    state       <= CLOSE;
                    pe_row_done <= PE_ONE << cur_pe;
                end
                CLOSE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_PES; i++) begin : PES
        matraptor_pe #(
            .DATA_W (DATA_W),
            .IDX_W  (IDX_W),
            .NQ     (NQ),
            .Q_DEPTH(Q_DEPTH)
        ) U_PE (
            .clk  (clk),
            .rst_n(rst_n),
            .wr_en(accept && (in_pe == PE_W'(i))),
            .first(state == IDLE),
            .clear((state == CLOSE) && (cur_pe == PE_W'(i))),
            .val  (in_val),
            .col  (in_col)
        );
    end

endmodule

// File: tb/tb_matraptor_spgemm_core.sv
// Directed + random bench: queue-run model checked against PE state whenever a row closes.
module tb_matraptor_spgemm_core;
    import matraptor_pkg::*;

    localparam int NQ = 8;
    localparam int QD = 4;
    localparam int NP = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_val = '0;
    logic [15:0]   in_row = '0;
    logic [15:0]   in_col = '0;
    logic          in_last = 1'b0;
    logic [NP-1:0] pe_row_done;

    always #5 clk = ~clk;

    matraptor_spgemm_core #(
        .DATA_W(32), .IDX_W(16), .NQ(NQ), .Q_DEPTH(QD), .NUM_PES(NP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_val(in_val), .in_row(in_row), .in_col(in_col), .in_last(in_last),
        .pe_row_done(pe_row_done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per PE, per queue, the list of accepted (col, val).
    logic [15:0] mcol [NP][NQ][$];
    logic [31:0] mval [NP][NQ][$];
    bit          movf [NP];
    bit          open;
    int          open_row;
    int          cur_q;
    int          last_col;
    int          pulses [NP];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] get_wp(input int p, input int q);
        if (p == 0) return 64'(dut.PES[0].U_PE.wr_ptr[q]);
        return 64'(dut.PES[1].U_PE.wr_ptr[q]);
    endfunction

    function automatic entry_t get_ent(input int p, input int q, input int i);
        if (p == 0) return dut.PES[0].U_PE.queue_mem[q][i];
        return dut.PES[1].U_PE.queue_mem[q][i];
    endfunction

    function automatic logic [63:0] get_ovf(input int p);
        if (p == 0) return 64'(dut.PES[0].U_PE.overflow);
        return 64'(dut.PES[1].U_PE.overflow);
    endfunction

    task automatic check_pe(input int p, input string tag);
        entry_t e;
        for (int q = 0; q < NQ; q++) begin
            chk($sformatf("%s_pe%0d_q%0d_depth", tag, p, q), get_wp(p, q), 64'(mcol[p][q].size()));
            for (int i = 0; i < mcol[p][q].size(); i++) begin
                e = get_ent(p, q, i);
                chk($sformatf("%s_pe%0d_q%0d_col%0d", tag, p, q, i), 64'(e.col), 64'(mcol[p][q][i]));
                chk($sformatf("%s_pe%0d_q%0d_val%0d", tag, p, q, i), 64'(e.val), 64'(mval[p][q][i]));
            end
        end
        chk($sformatf("%s_pe%0d_overflow", tag, p), get_ovf(p), 64'(movf[p]));
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            for (int q = 0; q < NQ; q++) begin
                mcol[p][q].delete();
                mval[p][q].delete();
            end
            movf[p] = 1'b0;
        end
        open = 1'b0;
    endtask

    task automatic model_accept(input int row, input int col, input logic [31:0] val);
        int p;
        p = row % NP;
        if (!open || row != open_row) begin
            open = 1'b1;
            open_row = row;
            cur_q = 0;
        end else if (col <= last_col) begin
            cur_q = (cur_q + 1) % NQ;
        end
        last_col = col;
        if (mcol[p][cur_q].size() < QD) begin
            mcol[p][cur_q].push_back(16'(col));
            mval[p][cur_q].push_back(val);
        end else begin
            movf[p] = 1'b1;
        end
    endtask

    // On every row-close pulse, the owner PE must hold exactly the model's row.
    always @(negedge clk) begin
        if (rst_n && pe_row_done !== '0) begin
            int own;
            own = open ? (open_row % NP) : 0;
            chk("pulse_onehot", 64'(pe_row_done), open ? (64'(1) << own) : 64'(0));
            for (int p = 0; p < NP; p++) check_pe(p, "close");
            if (open) begin
                pulses[own]++;
                for (int q = 0; q < NQ; q++) begin
                    mcol[own][q].delete();
                    mval[own][q].delete();
                end
                open = 1'b0;
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance with in_valid dropped.
    task automatic send(input int row, input int col, input logic [31:0] val, input bit last,
                        output int stall);
        bit done;
        done = 1'b0;
        stall = 0;
        in_valid = 1'b1;
        in_row = 16'(row);
        in_col = 16'(col);
        in_val = val;
        in_last = last;
        while (!done) begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                model_accept(row, col, val);
                done = 1'b1;
            end else begin
                stall++;
                if (stall > 20) begin
                    checks++;
                    errors++;
                    $error("FAIL ready_timeout: observed stall %0d expected <= 20", stall);
                    done = 1'b1;
                end
                @(posedge clk);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int p0, p1;
        logic [31:0] v3 [3];
        int c5 [5];
        v3 = '{32'h3f800000, 32'h40000000, 32'h40400000};
        c5 = '{4, 9, 1, 3, 0};
        model_reset();

        // Reset
        repeat (3) @(negedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_row_done", 64'(pe_row_done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);
        check_pe(0, "reset");
        check_pe(1, "reset");

        // Three ascending columns, in_last on the third
        send(0, 2, v3[0], 0, st);
        send(0, 5, v3[1], 0, st);
        send(0, 7, v3[2], 1, st);
        chk("t1_pulse", 64'(pe_row_done), 64'd1);
        @(negedge clk);
        #1;
        chk("t1_pulse_once", 64'(pe_row_done), 64'd0);
        chk("t1_idle_ready", 64'(in_ready), 64'd1);
        chk("t1_pulse_count", 64'(pulses[0]), 64'd1);

        // Runs split on non-ascending columns
        for (int k = 0; k < 5; k++) send(0, c5[k], 32'(10 + k), k == 4, st);
        idle(2);

        // Row change: two-cycle stall, then row 1 starts from queue 0
        send(0, 3, 32'h33, 0, st);
        send(0, 6, 32'h66, 0, st);
        send(1, 5, 32'h55, 0, st);
        chk("t3_stall", 64'(st), 64'd2);
        send(1, 8, 32'h88, 1, st);
        chk("t3_second_stall", 64'(st), 64'd0);
        idle(2);

        // Nine descending columns wrap q_sel back to queue 0
        for (int c = 8; c >= 0; c--) send(2, c, 32'(100 + c), c == 0, st);
        idle(2);

        // Overflow: six ascending columns into a depth-4 queue, never back-pressured
        for (int c = 1; c <= 6; c++) begin
            send(4, c, 32'(200 + c), c == 6, st);
            chk($sformatf("t5_no_stall%0d", c), 64'(st), 64'd0);
        end
        idle(2);

        // Rows 2 then 3 land on different PEs
        #1;
        p0 = pulses[0];
        p1 = pulses[1];
        send(2, 1, 32'h21, 0, st);
        send(2, 2, 32'h22, 0, st);
        send(3, 1, 32'h31, 1, st);
        idle(2);
        #1;
        chk("t6_pe0_pulses", 64'(pulses[0]), 64'(p0 + 1));
        chk("t6_pe1_pulses", 64'(pulses[1]), 64'(p1 + 1));

        // Randomized rows
        @(negedge clk);
        for (int r = 0; r < 25; r++) begin
            int row, n;
            bit lst;
            row = $urandom_range(0, 7);
            n = $urandom_range(1, 6);
            lst = 1'($urandom_range(0, 1));
            for (int k = 0; k < n; k++) begin
                send(row, $urandom_range(0, 15), $urandom, (k == n - 1) && lst, st);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        send(7, 1, 32'h77, 1, st);
        idle(3);
        chk("random_all_closed", 64'(open), 64'd0);

        // Reset while a row-change close is pending cancels the pulse
        send(5, 1, 32'h51, 0, st);
        in_valid = 1'b1;
        in_row = 16'd6;
        in_col = 16'd0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_cancel_pulse", 64'(pe_row_done), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_idle_ready", 64'(in_ready), 64'd1);
        check_pe(0, "rst");
        check_pe(1, "rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
